axil_reg_bridge: RTL and testbench

AXI4-Lite slave that acts as the initiator of the TLK2711 register bus. It converts PS-side AXI-Lite transactions into single-cycle reg-bus write and read strobes with 16-bit addresses and 64-bit data, then returns AXI responses. It sits between the Zynq MPSoC M_AXI_HPM port and the TLK2711 register-management block. It also conditions the tx/rx/loss interrupt pulses into a PS interrupt line.

---
 rtl/axil_reg_bridge.sv | 248 ++++++++++++++++++++++++
 tb/tb_axil_reg_bridge.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave driving the TLK2711 register bus with single-cycle write/read strobes.
// Define AXIL_REG_BRIDGE_IRQ_LATCH_EN for a sticky o_irq cleared by a read strobe to 16'h0100.
module axil_reg_bridge #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int RD_LATENCY     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                      s_axil_awvalid,
    output logic                      s_axil_awready,
    input  logic [63:0]               s_axil_wdata,
    input  logic [7:0]                s_axil_wstrb,
    input  logic                      s_axil_wvalid,
    output logic                      s_axil_wready,
    output logic [1:0]                s_axil_bresp,
    output logic                      s_axil_bvalid,
    input  logic                      s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                      s_axil_arvalid,
    output logic                      s_axil_arready,
    output logic [63:0]               s_axil_rdata,
    output logic [1:0]                s_axil_rresp,
    output logic                      s_axil_rvalid,
    input  logic                      s_axil_rready,
    output logic                      o_reg_wen,
    output logic [15:0]               o_reg_waddr,
    output logic [63:0]               o_reg_wdata,
    output logic                      o_reg_ren,
    output logic [15:0]               o_reg_raddr,
    input  logic [63:0]               i_reg_rdata,
    input  logic                      i_tx_irq,
    input  logic                      i_rx_irq,
    input  logic                      i_loss_irq,
    output logic                      o_irq
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_COLLECT = 3'd1,
        WR_STROBE  = 3'd2,
        WR_RESP    = 3'd3,
        RD_STROBE  = 3'd4,
        RD_WAIT    = 3'd5,
        RD_RESP    = 3'd6
    } state_t;

    localparam logic [2:0] RD_LAT_C = 3'(RD_LATENCY);

    function automatic logic addr_bad(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return |addr[AXI_ADDR_WIDTH-1:16];
    endfunction

    state_t                      state_r, next_state_s;
    logic                        prio_wr_r, aw_got_r, w_got_r;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr_r, aw_addr_s;
    logic [63:0]                 w_data_r, w_data_s;
    logic [7:0]                  w_strb_r, w_strb_s;
    logic [2:0]                  rd_cnt_r;
    logic                        conflict_s, awready_s, wready_s, arready_s;
    logic                        aw_hs_s, w_hs_s, ar_hs_s, aw_full_s, w_full_s, wr_err_s, rd_err_s;
    logic                        wen_r, ren_r, bvalid_r, rvalid_r, irq_r, irq_any_s;
    logic [15:0]                 waddr_r, raddr_r;
    logic [63:0]                 wdata_r, rdata_r;
    logic [1:0]                  bresp_r, rresp_r;

    // Channel readies; in IDLE the loser of a simultaneous write/read request is held off.
    always_comb begin
        awready_s  = 1'b0;
        wready_s   = 1'b0;
        arready_s  = 1'b0;
        conflict_s = (s_axil_awvalid | s_axil_wvalid) & s_axil_arvalid;
        if (rst) begin
            awready_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    awready_s = ~(conflict_s & ~prio_wr_r);
                    wready_s  = ~(conflict_s & ~prio_wr_r);
                    arready_s = ~(conflict_s & prio_wr_r);
                end
                WR_COLLECT: begin
                    awready_s = ~aw_got_r;
                    wready_s  = ~w_got_r;
                end
                default: begin
                    awready_s = 1'b0;
                end
            endcase
        end
    end

    assign aw_hs_s   = s_axil_awvalid & awready_s;
    assign w_hs_s    = s_axil_wvalid & wready_s;
    assign ar_hs_s   = s_axil_arvalid & arready_s;
    assign aw_full_s = aw_got_r | aw_hs_s;
    assign w_full_s  = w_got_r | w_hs_s;
    assign aw_addr_s = aw_got_r ? aw_addr_r : s_axil_awaddr;
    assign w_data_s  = w_got_r ? w_data_r : s_axil_wdata;
    assign w_strb_s  = w_got_r ? w_strb_r : s_axil_wstrb;
    assign wr_err_s  = addr_bad(aw_addr_s) | (w_strb_s != 8'hFF);
    assign rd_err_s  = addr_bad(s_axil_araddr);

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (ar_hs_s) begin
                    next_state_s = rd_err_s ? RD_RESP : RD_STROBE;
                end else if (aw_hs_s | w_hs_s) begin
                    if (aw_full_s & w_full_s) begin
                        next_state_s = wr_err_s ? WR_RESP : WR_STROBE;
                    end else begin
                        next_state_s = WR_COLLECT;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            WR_COLLECT: begin
                if (aw_full_s & w_full_s) begin
                    next_state_s = wr_err_s ? WR_RESP : WR_STROBE;
                end else begin
                    next_state_s = WR_COLLECT;
                end
            end
            WR_STROBE: next_state_s = WR_RESP;
            WR_RESP:   next_state_s = s_axil_bready ? IDLE : WR_RESP;
            RD_STROBE: next_state_s = RD_WAIT;
            RD_WAIT:   next_state_s = (rd_cnt_r == RD_LAT_C) ? RD_RESP : RD_WAIT;
            RD_RESP:   next_state_s = s_axil_rready ? IDLE : RD_RESP;
            default:   next_state_s = IDLE;
        endcase
    end

    // State, arbitration priority, AW/W capture buffers and read-latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            prio_wr_r <= 1'b1;
            aw_got_r  <= 1'b0;
            w_got_r   <= 1'b0;
            aw_addr_r <= '0;
            w_data_r  <= 64'd0;
            w_strb_r  <= 8'd0;
            rd_cnt_r  <= 3'd1;
        end else begin
            state_r <= next_state_s;
            if (aw_hs_s) aw_addr_r <= s_axil_awaddr;
            if (w_hs_s) begin
                w_data_r <= s_axil_wdata;
                w_strb_r <= s_axil_wstrb;
            end
            if (next_state_s == WR_COLLECT) begin
                aw_got_r <= aw_full_s;
                w_got_r  <= w_full_s;
            end else begin
                aw_got_r <= 1'b0;
                w_got_r  <= 1'b0;
            end
            if (ar_hs_s) begin
                prio_wr_r <= 1'b1;
            end else if ((state_r == IDLE) && (aw_hs_s | w_hs_s)) begin
                prio_wr_r <= 1'b0;
            end
            rd_cnt_r <= (state_r == RD_WAIT) ? rd_cnt_r + 3'd1 : 3'd1;
        end
    end

    // Registered strobes and responses, loaded on entry to the matching state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_r    <= 1'b0;
            ren_r    <= 1'b0;
            bvalid_r <= 1'b0;
            rvalid_r <= 1'b0;
            waddr_r  <= 16'd0;
            wdata_r  <= 64'd0;
            raddr_r  <= 16'd0;
            rdata_r  <= 64'd0;
            bresp_r  <= 2'b00;
            rresp_r  <= 2'b00;
        end else begin
            wen_r    <= (next_state_s == WR_STROBE);
            ren_r    <= (next_state_s == RD_STROBE);
            bvalid_r <= (next_state_s == WR_RESP);
            rvalid_r <= (next_state_s == RD_RESP);
            if (next_state_s == WR_STROBE) begin
                waddr_r <= aw_addr_s[15:0];
                wdata_r <= w_data_s;
            end
            if (next_state_s == RD_STROBE) raddr_r <= s_axil_araddr[15:0];
            if ((next_state_s == WR_RESP) && (state_r != WR_RESP)) begin
                bresp_r <= (state_r == WR_STROBE) ? 2'b00 : 2'b10;
            end
            if ((next_state_s == RD_RESP) && (state_r != RD_RESP)) begin
                if (state_r == RD_WAIT) begin
                    rresp_r <= 2'b00;
                    rdata_r <= i_reg_rdata;
                end else begin
                    rresp_r <= 2'b10;
                    rdata_r <= 64'd0;
                end
            end
        end
    end

    assign irq_any_s = i_tx_irq | i_rx_irq | i_loss_irq;

`ifdef AXIL_REG_BRIDGE_IRQ_LATCH_EN
    // Sticky interrupt; a new pulse beats the clear from a status read of 16'h0100.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_r <= 1'b0;
        end else if (irq_any_s) begin
            irq_r <= 1'b1;
        end else if (ren_r && (raddr_r == 16'h0100)) begin
            irq_r <= 1'b0;
        end
    end
`else
    // Registered OR of the interrupt pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_any_s;
        end
    end
`endif

    assign s_axil_awready = awready_s;
    assign s_axil_wready  = wready_s;
    assign s_axil_arready = arready_s;
    assign s_axil_bvalid  = bvalid_r;
    assign s_axil_bresp   = bresp_r;
    assign s_axil_rvalid  = rvalid_r;
    assign s_axil_rresp   = rresp_r;
    assign s_axil_rdata   = rdata_r;
    assign o_reg_wen      = wen_r;
    assign o_reg_waddr    = waddr_r;
    assign o_reg_wdata    = wdata_r;
    assign o_reg_ren      = ren_r;
    assign o_reg_raddr    = raddr_r;
    assign o_irq          = irq_r;

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Directed self-checking bench for axil_reg_bridge; a register-bus model answers reads RD_LATENCY cycles after the strobe.
module tb_axil_reg_bridge;
    localparam int AW  = 32;
    localparam int RDL = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] s_axil_awaddr, s_axil_araddr;
    logic          s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
    logic [63:0]   s_axil_wdata, s_axil_rdata, o_reg_wdata, i_reg_rdata;
    logic [7:0]    s_axil_wstrb;
    logic [1:0]    s_axil_bresp, s_axil_rresp;
    logic          s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
    logic          s_axil_rvalid, s_axil_rready;
    logic          o_reg_wen, o_reg_ren, i_tx_irq, i_rx_irq, i_loss_irq, o_irq;
    logic [15:0]   o_reg_waddr, o_reg_raddr;

    int          errors = 0;
    int          checks = 0;
    int          wen_cnt = 0;
    int          ren_cnt = 0;
    int          overlap_cnt = 0;
    int          ord_n = 0;
    logic [15:0] ord_bits = 16'h0000;
    logic [7:0]  ren_hist = 8'h00;

    always #5 clk = ~clk;

    axil_reg_bridge #(.AXI_ADDR_WIDTH(AW), .RD_LATENCY(RDL)) dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .o_reg_wen(o_reg_wen), .o_reg_waddr(o_reg_waddr), .o_reg_wdata(o_reg_wdata),
        .o_reg_ren(o_reg_ren), .o_reg_raddr(o_reg_raddr), .i_reg_rdata(i_reg_rdata),
        .i_tx_irq(i_tx_irq), .i_rx_irq(i_rx_irq), .i_loss_irq(i_loss_irq), .o_irq(o_irq)
    );

    // Register-bus model: data is valid only on the cycle exactly RDL after the strobe.
    assign i_reg_rdata = ren_hist[RDL-1] ?
                         ((o_reg_raddr == 16'h0100) ? 64'h2000_0000_0005_0366 : {48'h0, o_reg_raddr}) :
                         64'hDEAD_BEEF_DEAD_BEEF;

    // Strobe monitor: counts, order log (1 = write, 0 = read) and overlap detection.
    always @(posedge clk) begin
        ren_hist <= {ren_hist[6:0], o_reg_ren};
        if (o_reg_wen) wen_cnt <= wen_cnt + 1;
        if (o_reg_ren) ren_cnt <= ren_cnt + 1;
        if (o_reg_wen && o_reg_ren) overlap_cnt <= overlap_cnt + 1;
        if (o_reg_wen || o_reg_ren) begin
            ord_bits <= {ord_bits[14:0], o_reg_wen};
            ord_n    <= ord_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    initial begin
        int   w0, r0, n, nw, nr, rv_seen;
        logic aw_t, ar_t;
        rst = 1'b1;
        s_axil_awaddr = '0; s_axil_awvalid = 1'b0; s_axil_wdata = 64'd0; s_axil_wstrb = 8'h00;
        s_axil_wvalid = 1'b0; s_axil_bready = 1'b0; s_axil_araddr = '0; s_axil_arvalid = 1'b0;
        s_axil_rready = 1'b0; i_tx_irq = 1'b0; i_rx_irq = 1'b0; i_loss_irq = 1'b0;
        tick(); tick();
        chk("rst_ctl", {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid,
                        s_axil_rvalid, o_reg_wen, o_reg_ren, o_irq}, 8'h00);
        chk("rst_data", {o_reg_waddr, o_reg_raddr, s_axil_bresp, s_axil_rresp}, 36'h0);
        chk("rst_wdata", o_reg_wdata, 64'h0);
        chk("rst_rdata", s_axil_rdata, 64'h0);
        rst = 1'b0;
        tick();
        chk("idle_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);

        // Test 1: AW and W together, bready held low for 5 cycles.
        w0 = wen_cnt;
        s_axil_awaddr = 32'h0000_0108; s_axil_wdata = 64'h0000_0000_8000_0000; s_axil_wstrb = 8'hFF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        #1 chk("t1_ready", {s_axil_awready, s_axil_wready}, 2'b11);
        tick();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        chk("t1_wen", o_reg_wen, 1'b1);
        chk("t1_waddr", o_reg_waddr, 16'h0108);
        chk("t1_wdata", o_reg_wdata, 64'h0000_0000_8000_0000);
        chk("t1_bvalid_early", s_axil_bvalid, 1'b0);
        tick();
        chk("t1_wen_drop", o_reg_wen, 1'b0);
        chk("t1_bresp", {s_axil_bvalid, s_axil_bresp}, 3'b100);
        repeat (5) tick();
        chk("t1_bhold", s_axil_bvalid, 1'b1);
        chk("t1_busy_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b000);
        s_axil_bready = 1'b1;
        tick();
        chk("t1_bdone", s_axil_bvalid, 1'b0);
        chk("t1_wen_count", wen_cnt - w0, 1);

        // Test 2: W three cycles before AW.
        w0 = wen_cnt;
        s_axil_wdata = 64'h1000_0000_0001_0366; s_axil_wstrb = 8'hFF; s_axil_wvalid = 1'b1;
        #1 chk("t2_wready", s_axil_wready, 1'b1);
        tick();
        s_axil_wvalid = 1'b0;
        chk("t2_collect", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b100);
        tick(); tick();
        chk("t2_no_wen", o_reg_wen, 1'b0);
        s_axil_awaddr = 32'h0000_0118; s_axil_awvalid = 1'b1;
        #1 chk("t2_awready", s_axil_awready, 1'b1);
        tick();
        s_axil_awvalid = 1'b0;
        chk("t2_wen", o_reg_wen, 1'b1);
        chk("t2_waddr", o_reg_waddr, 16'h0118);
        chk("t2_wdata", o_reg_wdata, 64'h1000_0000_0001_0366);
        chk("t2_awready_drop", s_axil_awready, 1'b0);
        tick();
        chk("t2_bresp", {s_axil_bvalid, s_axil_bresp}, 3'b100);
        tick();
        chk("t2_bdone", s_axil_bvalid, 1'b0);
        chk("t2_wen_count", wen_cnt - w0, 1);

        // Test 3: good read of 0x0100 with rready held low briefly.
        r0 = ren_cnt;
        s_axil_araddr = 32'h0000_0100; s_axil_arvalid = 1'b1;
        #1 chk("t3_arready", s_axil_arready, 1'b1);
        tick();
        s_axil_arvalid = 1'b0;
        chk("t3_ren", o_reg_ren, 1'b1);
        chk("t3_raddr", o_reg_raddr, 16'h0100);
        n = 0;
        while (!s_axil_rvalid && n < 20) begin
            tick();
            n++;
        end
        chk("t3_latency", n, RDL + 1);
        chk("t3_rdata", s_axil_rdata, 64'h2000_0000_0005_0366);
        chk("t3_rresp", s_axil_rresp, 2'b00);
        tick(); tick();
        chk("t3_rhold", {s_axil_rvalid, s_axil_rresp}, 3'b100);
        chk("t3_rdata_hold", s_axil_rdata, 64'h2000_0000_0005_0366);
        s_axil_rready = 1'b1;
        tick();
        chk("t3_rdone", s_axil_rvalid, 1'b0);
        chk("t3_ren_count", ren_cnt - r0, 1);

        // Test 4: error responses.
        w0 = wen_cnt;
        s_axil_awaddr = 32'h0001_0008; s_axil_wdata = 64'h1; s_axil_wstrb = 8'hFF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        tick();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        chk("t4a_resp", {s_axil_bvalid, s_axil_bresp}, 3'b110);
        chk("t4a_no_wen", o_reg_wen, 1'b0);
        tick();
        chk("t4a_bdone", s_axil_bvalid, 1'b0);
        s_axil_awaddr = 32'h0000_0008; s_axil_wstrb = 8'h0F;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        tick();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        chk("t4b_resp", {s_axil_bvalid, s_axil_bresp}, 3'b110);
        tick();
        chk("t4_wen_count", wen_cnt - w0, 0);
        r0 = ren_cnt;
        s_axil_araddr = 32'h0002_0000; s_axil_arvalid = 1'b1;
        tick();
        s_axil_arvalid = 1'b0;
        chk("t4c_resp", {s_axil_rvalid, s_axil_rresp}, 3'b110);
        chk("t4c_rdata", s_axil_rdata, 64'h0);
        chk("t4c_no_ren", o_reg_ren, 1'b0);
        tick();
        chk("t4c_rdone", s_axil_rvalid, 1'b0);
        chk("t4c_ren_count", ren_cnt - r0, 0);

        // Test 5: simultaneous AW+W+AR twice after reset -> W, R, W, R.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        w0 = ord_n;
        s_axil_awaddr = 32'h0000_0010; s_axil_wdata = 64'h55; s_axil_wstrb = 8'hFF;
        s_axil_araddr = 32'h0000_0020;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
        #1 chk("t5_arb_first", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b110);
        nw = 0; nr = 0;
        for (int c = 0; c < 80 && (nw < 2 || nr < 2); c++) begin
            @(negedge clk);
            aw_t = s_axil_awvalid & s_axil_awready;
            ar_t = s_axil_arvalid & s_axil_arready;
            tick();
            if (aw_t) begin
                nw++;
                if (nw == 2) begin s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; end
            end
            if (ar_t) begin
                nr++;
                if (nr == 2) s_axil_arvalid = 1'b0;
            end
        end
        repeat (6) tick();
        chk("t5_count", ord_n - w0, 4);
        chk("t5_order", ord_bits[3:0], 4'b1010);
        chk("t5_overlap", overlap_cnt, 0);

        // Test 6: interrupt conditioning.
        i_rx_irq = 1'b1;
        #1 chk("t6_pre", o_irq, 1'b0);
        tick();
        i_rx_irq = 1'b0;
        chk("t6_irq_on", o_irq, 1'b1);
        tick();
`ifdef AXIL_REG_BRIDGE_IRQ_LATCH_EN
        chk("t6_irq_sticky", o_irq, 1'b1);
        s_axil_araddr = 32'h0000_0100; s_axil_arvalid = 1'b1;
        tick();
        s_axil_arvalid = 1'b0;
        i_tx_irq = 1'b1;
        tick();
        i_tx_irq = 1'b0;
        chk("t6_set_wins", o_irq, 1'b1);
        repeat (6) tick();
        s_axil_arvalid = 1'b1;
        tick();
        s_axil_arvalid = 1'b0;
        tick();
        chk("t6_clear", o_irq, 1'b0);
        repeat (6) tick();
`else
        chk("t6_irq_off", o_irq, 1'b0);
`endif

        // Reset while waiting for read data: no response, no further strobes.
        s_axil_araddr = 32'h0000_0100; s_axil_arvalid = 1'b1;
        tick();
        s_axil_arvalid = 1'b0;
        tick();
        r0 = ren_cnt; w0 = wen_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rv_seen = 0;
        repeat (10) begin
            tick();
            if (s_axil_rvalid) rv_seen++;
        end
        chk("rst_rvalid", rv_seen, 0);
        chk("rst_strobes", (ren_cnt - r0) + (wen_cnt - w0), 0);
        chk("rst_idle", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
